// File: rtl/victim_buffer_if.sv
// Victim buffer signal bundle: evict, recall, flush and memory-store lines.
interface victim_buffer_if #(
  parameter int IDX_W = 29,
  parameter int BLK_W = 64,
  parameter int CNT_W = 4
) ();
  logic             evict_valid;
  logic             evict_ready;
  logic             evict_dirty;
  logic [IDX_W-1:0] evict_idx;
  logic [BLK_W-1:0] evict_blk;
  logic             recall_valid;
  logic [IDX_W-1:0] recall_idx;
  logic             recall_take;
  logic             recall_found;
  logic [BLK_W-1:0] recall_blk;
  logic             flush;
  logic             flush_done;
  logic [1:0]       t_command;
  logic [31:0]      t_addr;
  logic [BLK_W-1:0] t_data;
  logic [3:0]       r_response;
  logic [CNT_W-1:0] count;

  // Buffer side.
  modport slave (
    input  evict_valid, evict_dirty, evict_idx, evict_blk,
           recall_valid, recall_idx, recall_take, flush, r_response,
    output evict_ready, recall_found, recall_blk, flush_done,
           t_command, t_addr, t_data, count
  );

  // Cache / memory side.
  modport master (
    output evict_valid, evict_dirty, evict_idx, evict_blk,
           recall_valid, recall_idx, recall_take, flush, r_response,
    input  evict_ready, recall_found, recall_blk, flush_done,
           t_command, t_addr, t_data, count
  );
endinterface

// File: rtl/victim_buffer.sv
// Victim buffer: circular FIFO of evicted L1 blocks with recall lookup,
// re-eviction merging and dirty write-back through the STORE handshake.
module victim_buffer #(
  parameter int DEPTH     = 8,
  parameter int BLK_W     = 64,
  parameter int OFF_W     = $clog2(BLK_W / 8),
  parameter int IDX_W     = 32 - OFF_W,
  parameter int WB_THRESH = DEPTH - 2
) (
  input logic            clock,
  input logic            reset,
  victim_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] MEM_CMD_NONE  = 2'd0;
  localparam logic [1:0] MEM_CMD_STORE = 2'd2;

  typedef enum logic {WB_IDLE, WB_BUSY} wb_state_e;

  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_dirty;
  logic [IDX_W-1:0] slot_idx [DEPTH];
  logic [BLK_W-1:0] slot_blk [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  wb_state_e        state;
  logic             flushing;
  logic [IDX_W-1:0] wb_idx;
  logic [BLK_W-1:0] wb_blk;

  logic [DEPTH-1:0] in_flight;
  logic [DEPTH-1:0] recall_hit;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] evict_hit;
  logic             recall_found;
  logic [BLK_W-1:0] recall_blk;
  logic             found_nf;
  logic             take_fire;
  logic             merge_hit;
  logic [PTR_W-1:0] merge_slot;
  logic             full;
  logic             empty;
  logic             head_live;
  logic             evict_ready;
  logic             evict_fire;
  logic             merge_fire;
  logic             alloc_fire;
  logic             discard_fire;
  logic             retire;
  logic             wb_start;
  logic             wb_accept;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Recall lookup; a duplicate index can only be the in-flight head plus a fresh copy, so the fresh copy wins.
  always_comb begin
    in_flight  = '0;
    recall_hit = '0;
    recall_blk = '0;
    found_nf   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      in_flight[i]  = (state == WB_BUSY) && (head == PTR_W'(i));
      recall_hit[i] = slot_valid[i] && (slot_idx[i] == bus.recall_idx);
    end
    recall_found = bus.recall_valid && (|recall_hit);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (recall_hit[i] && !in_flight[i] && !found_nf) begin
        recall_blk = slot_blk[i];
        found_nf   = 1'b1;
      end
    end
    if (!found_nf) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (recall_hit[i] && in_flight[i]) recall_blk = slot_blk[i];
      end
    end
    if (!recall_found) recall_blk = '0;
  end

  // Evict acceptance, seen after this cycle's take has removed its entries.
  always_comb begin
    take_fire  = recall_found && bus.recall_take;
    live       = slot_valid & ~(take_fire ? recall_hit : '0);
    evict_hit  = '0;
    merge_hit  = 1'b0;
    merge_slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      evict_hit[i] = live[i] && !in_flight[i] && (slot_idx[i] == bus.evict_idx);
      if (evict_hit[i] && !merge_hit) begin
        merge_hit  = 1'b1;
        merge_slot = PTR_W'(i);
      end
    end
    full      = (count == CNT_W'(DEPTH));
    empty     = (count == '0);
    head_live = live[head];

    if (flushing)                                                evict_ready = 1'b0;
    else if (merge_hit)                                          evict_ready = 1'b1;
    else if (!full)                                              evict_ready = 1'b1;
    else if (state == WB_IDLE && (!head_live || !slot_dirty[head])) evict_ready = 1'b1;
    else                                                         evict_ready = 1'b0;

    evict_fire   = bus.evict_valid && evict_ready;
    merge_fire   = evict_fire && merge_hit;
    alloc_fire   = evict_fire && !merge_hit;
    discard_fire = alloc_fire && full;

    retire    = (state == WB_IDLE) && !empty &&
                (!head_live || (flushing && !slot_dirty[head]));
    // A merge landing on the head this cycle would make the latched copy stale, so wait a cycle.
    wb_start  = (state == WB_IDLE) && !empty && head_live && slot_dirty[head] &&
                ((int'(count) >= WB_THRESH) || full || flushing) &&
                !(merge_fire && (merge_slot == head));
    wb_accept = (state == WB_BUSY) && (bus.r_response != 4'd0);
    pop       = retire || wb_accept || discard_fire;
  end

  // Slot status, FIFO pointers, occupancy, write-back FSM and flush tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      slot_dirty <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      state      <= WB_IDLE;
      flushing   <= 1'b0;
      wb_idx     <= '0;
      wb_blk     <= '0;
    end else begin
      slot_valid <= live;
      if (pop) begin
        slot_valid[head] <= 1'b0;
        head             <= ptr_inc(head);
      end
      if (merge_fire) slot_dirty[merge_slot] <= slot_dirty[merge_slot] | bus.evict_dirty;
      // On a full-buffer discard tail equals head, so this allocation overrides the pop above.
      if (alloc_fire) begin
        slot_valid[tail] <= 1'b1;
        slot_dirty[tail] <= bus.evict_dirty;
        tail             <= ptr_inc(tail);
      end
      if (alloc_fire && !pop)      count <= count + CNT_W'(1);
      else if (pop && !alloc_fire) count <= count - CNT_W'(1);

      case (state)
        WB_IDLE: if (wb_start) begin
          state  <= WB_BUSY;
          wb_idx <= slot_idx[head];
          wb_blk <= slot_blk[head];
        end
        WB_BUSY: if (wb_accept) state <= WB_IDLE;
        default: state <= WB_IDLE;
      endcase

      if (flushing && empty) flushing <= 1'b0;
      if (bus.flush)         flushing <= 1'b1;
    end
  end

  // Slot payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clock) begin
    if (merge_fire) slot_blk[merge_slot] <= bus.evict_blk;
    if (alloc_fire) begin
      slot_idx[tail] <= bus.evict_idx;
      slot_blk[tail] <= bus.evict_blk;
    end
  end

  assign bus.evict_ready  = evict_ready;
  assign bus.recall_found = recall_found;
  assign bus.recall_blk   = recall_blk;
  assign bus.flush_done   = flushing && empty;
  assign bus.t_command    = (state == WB_BUSY) ? MEM_CMD_STORE : MEM_CMD_NONE;
  assign bus.t_addr       = (state == WB_BUSY) ? {wb_idx, {OFF_W{1'b0}}} : '0;
  assign bus.t_data       = (state == WB_BUSY) ? wb_blk : '0;
  assign bus.count        = count;
endmodule

// File: tb/tb_victim_buffer.sv
// Directed self-checking bench for victim_buffer (DEPTH=8, BLK_W=64).
module tb_victim_buffer;
  localparam int DEPTH = 8;
  localparam int BLK_W = 64;
  localparam int IDX_W = 29;
  localparam int CNT_W = 4;
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic        clock;
  logic        reset;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] st_addr[$];
  int          n_done;

  victim_buffer_if #(.IDX_W(IDX_W), .BLK_W(BLK_W), .CNT_W(CNT_W)) bus ();

  victim_buffer #(.DEPTH(DEPTH), .BLK_W(BLK_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [BLK_W-1:0] blk_of(input logic [IDX_W-1:0] idx);
    return {32'hCAFE_0000 | 32'(idx), 32'h5A5A_5A5A ^ 32'(idx)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic evict(input logic dirty, input logic [IDX_W-1:0] idx, input logic [BLK_W-1:0] blk);
    bus.evict_valid = 1'b1;
    bus.evict_dirty = dirty;
    bus.evict_idx   = idx;
    bus.evict_blk   = blk;
    #1;
    check_eq("evict_ready", 64'(bus.evict_ready), 64'd1);
    tick();
    bus.evict_valid = 1'b0;
    bus.evict_dirty = 1'b0;
  endtask

  task automatic lookup(input logic [IDX_W-1:0] idx, input logic found, input logic [BLK_W-1:0] blk);
    bus.recall_valid = 1'b1;
    bus.recall_idx   = idx;
    #1;
    check_eq("recall_found", 64'(bus.recall_found), 64'(found));
    check_eq("recall_blk", 64'(bus.recall_blk), 64'(blk));
    bus.recall_valid = 1'b0;
  endtask

  task automatic flush_and_drain(input int cycles);
    bus.flush      = 1'b1;
    bus.r_response = 4'd1;
    tick();
    bus.flush = 1'b0;
    check_eq("flush_blocks_evict", 64'(bus.evict_ready), 64'd0);
    st_addr.delete();
    n_done = 0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.t_command == CMD_STORE) st_addr.push_back(bus.t_addr);
      if (bus.flush_done) n_done++;
      tick();
    end
    bus.r_response = 4'd0;
  endtask

  task automatic check_stores(input string tag, input logic [31:0] exp[$]);
    check_eq({tag, "_nstores"}, 64'(st_addr.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size(); k++)
      check_eq({tag, "_addr"}, (k < st_addr.size()) ? 64'(st_addr[k]) : 64'hFFFF_FFFF, 64'(exp[k]));
    check_eq({tag, "_done_pulses"}, 64'(n_done), 64'd1);
    check_eq({tag, "_count"}, 64'(bus.count), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_d[$];
    logic [31:0] exp_e[$];
    reset            = 1'b1;
    bus.evict_valid  = 1'b0;
    bus.evict_dirty  = 1'b0;
    bus.evict_idx    = '0;
    bus.evict_blk    = '0;
    bus.recall_valid = 1'b0;
    bus.recall_idx   = '0;
    bus.recall_take  = 1'b0;
    bus.flush        = 1'b0;
    bus.r_response   = 4'd0;
    #2;
    check_eq("rst_t_command", 64'(bus.t_command), 64'(CMD_NONE));
    check_eq("rst_t_addr", 64'(bus.t_addr), 64'd0);
    check_eq("rst_t_data", 64'(bus.t_data), 64'd0);
    check_eq("rst_count", 64'(bus.count), 64'd0);
    check_eq("rst_evict_ready", 64'(bus.evict_ready), 64'd1);
    check_eq("rst_flush_done", 64'(bus.flush_done), 64'd0);
    #5;
    reset = 1'b0;
    tick();

    // Three clean evicts, recall hit and miss, no write-back.
    for (int i = 0; i < 3; i++) evict(1'b0, IDX_W'(32'h10 + i), blk_of(IDX_W'(32'h10 + i)));
    check_eq("a_count", 64'(bus.count), 64'd3);
    lookup(IDX_W'(32'h11), 1'b1, blk_of(IDX_W'(32'h11)));
    lookup(IDX_W'(32'h13), 1'b0, '0);
    tick();
    tick();
    check_eq("a_no_store", 64'(bus.t_command), 64'(CMD_NONE));

    // Eight dirty evicts: eager write-back once occupancy reaches the threshold.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      evict(1'b1, IDX_W'(i), blk_of(IDX_W'(i)));
      check_eq("b_cmd_after_evict", 64'(bus.t_command), (i >= 6) ? 64'(CMD_STORE) : 64'(CMD_NONE));
    end
    check_eq("b_count_full", 64'(bus.count), 64'd8);
    for (int c = 0; c < 5; c++) tick();
    check_eq("b_hold_cmd", 64'(bus.t_command), 64'(CMD_STORE));
    check_eq("b_hold_addr", 64'(bus.t_addr), 64'h0);
    check_eq("b_hold_data", 64'(bus.t_data), 64'(blk_of(IDX_W'(0))));
    bus.evict_valid = 1'b1;
    bus.evict_dirty = 1'b1;
    bus.evict_idx   = IDX_W'(32'h30);
    bus.evict_blk   = blk_of(IDX_W'(32'h30));
    #1;
    check_eq("b_full_dirty_ready", 64'(bus.evict_ready), 64'd0);
    bus.evict_valid = 1'b0;
    evict(1'b0, IDX_W'(5), 64'h0123_4567_89AB_CDEF);
    check_eq("b_merge_count", 64'(bus.count), 64'd8);
    lookup(IDX_W'(5), 1'b1, 64'h0123_4567_89AB_CDEF);
    bus.r_response = 4'd1;
    tick();
    bus.r_response = 4'd0;
    check_eq("b_accept_count", 64'(bus.count), 64'd7);
    check_eq("b_accept_cmd", 64'(bus.t_command), 64'(CMD_NONE));
    lookup(IDX_W'(0), 1'b0, '0);
    tick();
    check_eq("b_next_cmd", 64'(bus.t_command), 64'(CMD_STORE));
    check_eq("b_next_addr", 64'(bus.t_addr), 64'h8);
    check_eq("b_next_data", 64'(bus.t_data), 64'(blk_of(IDX_W'(1))));

    // Reset in the middle of a store abandons it.
    do_reset();
    check_eq("r_cmd", 64'(bus.t_command), 64'(CMD_NONE));
    check_eq("r_count", 64'(bus.count), 64'd0);
    for (int c = 0; c < 3; c++) tick();
    check_eq("r_cmd_later", 64'(bus.t_command), 64'(CMD_NONE));

    // Full of clean blocks: a new evict discards the head in the same cycle.
    for (int i = 0; i < DEPTH; i++) evict(1'b0, IDX_W'(32'h20 + i), blk_of(IDX_W'(32'h20 + i)));
    check_eq("c_count", 64'(bus.count), 64'd8);
    check_eq("c_no_store", 64'(bus.t_command), 64'(CMD_NONE));
    evict(1'b0, IDX_W'(32'h40), blk_of(IDX_W'(32'h40)));
    check_eq("c_count_after", 64'(bus.count), 64'd8);
    lookup(IDX_W'(32'h20), 1'b0, '0);
    lookup(IDX_W'(32'h40), 1'b1, blk_of(IDX_W'(32'h40)));

    // Take mid-FIFO, then flush: taken slot drops out silently.
    do_reset();
    for (int i = 1; i <= 3; i++) evict(1'b1, IDX_W'(i), blk_of(IDX_W'(i)));
    bus.recall_valid = 1'b1;
    bus.recall_idx   = IDX_W'(3);
    bus.recall_take  = 1'b1;
    #1;
    check_eq("d_take_found", 64'(bus.recall_found), 64'd1);
    tick();
    bus.recall_take = 1'b0;
    #1;
    check_eq("d_found_after_take", 64'(bus.recall_found), 64'd0);
    bus.recall_valid = 1'b0;
    for (int i = 4; i <= 5; i++) evict(1'b1, IDX_W'(i), blk_of(IDX_W'(i)));
    check_eq("d_count", 64'(bus.count), 64'd5);
    flush_and_drain(40);
    exp_d = '{32'h8, 32'h10, 32'h20, 32'h28};
    check_stores("d", exp_d);

    // Flush on an empty buffer completes on the next cycle.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("e0_done", 64'(bus.flush_done), 64'd1);
    tick();
    check_eq("e0_done_cleared", 64'(bus.flush_done), 64'd0);

    // Flush with two dirty entries and one clean one.
    do_reset();
    evict(1'b1, IDX_W'(32'h50), blk_of(IDX_W'(32'h50)));
    evict(1'b0, IDX_W'(32'h51), blk_of(IDX_W'(32'h51)));
    evict(1'b1, IDX_W'(32'h52), blk_of(IDX_W'(32'h52)));
    flush_and_drain(30);
    exp_e = '{32'h280, 32'h290};
    check_stores("e", exp_e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
